tick_counter_ctrl: RTL and testbench

TICK_COUNTER_CTRL -- requirements
Module: tick_counter_ctrl

---
 rtl/tick_counter_ctrl.sv | 115 +++++++++++
 tb/tb_tick_counter_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_counter_ctrl.sv
// Push-button controlled modulo counter: synchronised and debounced button cycles the mode
// UP -> DOWN -> PAUSE, while a free-running prescaler paces the count steps.
module tick_counter_ctrl #(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned MODULO   = 8,
  parameter int unsigned DIV      = 100,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       mode,
  output logic             tick,
  output logic             btn_pulse
);

  localparam int unsigned PcntW = $clog2(DIV);
  localparam int unsigned DcntW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [PcntW-1:0] PcntMax  = PcntW'(DIV - 1);
  localparam logic [DcntW-1:0] DcntMax  = DcntW'(DEBOUNCE - 1);
  localparam logic [WIDTH-1:0] CountMax = WIDTH'(MODULO - 1);

  typedef enum logic [1:0] {
    ModeUp    = 2'b00,
    ModeDown  = 2'b01,
    ModePause = 2'b10
  } mode_e;

  logic [1:0]       sync_q;
  logic             deb_q, deb_d;
  logic [DcntW-1:0] dcnt_q, dcnt_d;
  logic [PcntW-1:0] pcnt_q, pcnt_d;
  logic             tick_q, tick_d;
  logic             pulse_q, pulse_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             press;
  logic             wrap;

  // Debounce: accept a new level only after DEBOUNCE consecutive disagreeing samples.
  always_comb begin
    deb_d  = deb_q;
    dcnt_d = dcnt_q;
    press  = 1'b0;
    if (sync_q[1] == deb_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DcntMax) begin
      deb_d  = sync_q[1];
      dcnt_d = '0;
      press  = sync_q[1];
    end else begin
      dcnt_d = dcnt_q + DcntW'(1);
    end
  end

  always_comb begin
    wrap   = (pcnt_q == PcntMax);
    pcnt_d = wrap ? '0 : pcnt_q + PcntW'(1);
    tick_d = wrap;
  end

  always_comb begin
    mode_d  = mode_q;
    pulse_d = press;
    if (press) begin
      unique case (mode_q)
        ModeUp:    mode_d = ModeDown;
        ModeDown:  mode_d = ModePause;
        ModePause: mode_d = ModeUp;
        default:   mode_d = ModeUp;
      endcase
    end
  end

  // Count steps on the prescaler wrap edge, using the mode held before that edge.
  always_comb begin
    count_d = count_q;
    if (wrap) begin
      unique case (mode_q)
        ModeUp:   count_d = (count_q == CountMax) ? '0 : count_q + WIDTH'(1);
        ModeDown: count_d = (count_q == '0) ? CountMax : count_q - WIDTH'(1);
        default:  count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      deb_q   <= 1'b0;
      dcnt_q  <= '0;
      pcnt_q  <= '0;
      tick_q  <= 1'b0;
      pulse_q <= 1'b0;
      mode_q  <= ModeUp;
      count_q <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn};
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
      pcnt_q  <= pcnt_d;
      tick_q  <= tick_d;
      pulse_q <= pulse_d;
      mode_q  <= mode_d;
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  assign mode      = mode_q;
  assign tick      = tick_q;
  assign btn_pulse = pulse_q;

endmodule

// File: tb/tb_tick_counter_ctrl.sv
// Bench for tick_counter_ctrl: constant vector table, corner-case sequences and a
// randomized run against an edge-counting reference model.
module tb_tick_counter_ctrl;

  localparam int unsigned WIDTH    = 3;
  localparam int unsigned MODULO   = 6;
  localparam int unsigned DIV      = 4;
  localparam int unsigned DEBOUNCE = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             btn = 1'b0;
  logic [WIDTH-1:0] count;
  logic [1:0]       mode;
  logic             tick;
  logic             btn_pulse;

  int n_checks = 0;
  int n_pass   = 0;

  tick_counter_ctrl #(
    .WIDTH   (WIDTH),
    .MODULO  (MODULO),
    .DIV     (DIV),
    .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn      (btn),
    .count    (count),
    .mode     (mode),
    .tick     (tick),
    .btn_pulse(btn_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  // Reference model: time measured as edges since reset, debounce as a run length.
  int   m_count, m_mode, m_edges, m_run;
  logic m_deb, m_h0, m_h1, m_tick, m_pulse;

  task automatic model_edge(input logic b, input logic r);
    logic s;
    logic press;
    logic tick_now;
    if (r) begin
      m_count = 0; m_mode = 0; m_edges = 0; m_run = 0;
      m_deb = 0; m_h0 = 0; m_h1 = 0; m_tick = 0; m_pulse = 0;
    end else begin
      s     = m_h1;
      press = 1'b0;
      if (s == m_deb) begin
        m_run = 0;
      end else begin
        m_run++;
        if (m_run == int'(DEBOUNCE)) begin
          m_deb = s;
          m_run = 0;
          press = s;
        end
      end
      m_edges++;
      tick_now = ((m_edges % DIV) == 0);
      if (tick_now) begin
        if (m_mode == 0) m_count = (m_count + 1) % MODULO;
        else if (m_mode == 1) m_count = (m_count + MODULO - 1) % MODULO;
      end
      if (press) m_mode = (m_mode + 1) % 3;
      m_tick  = tick_now;
      m_pulse = press;
      m_h1    = m_h0;
      m_h0    = b;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // One clock: drive inputs, let the edge happen, sample 1 time unit later.
  task automatic step(input logic b, input logic r);
    btn   = b;
    reset = r;
    @(posedge clk);
    #1;
    model_edge(b, r);
    check("mdl_count", int'(count), m_count);
    check("mdl_mode", int'(mode), m_mode);
    check("mdl_tick", int'(tick), int'(m_tick));
    check("mdl_pulse", int'(btn_pulse), int'(m_pulse));
    check("count_range", int'(count < WIDTH'(MODULO)), 1);
  endtask

  typedef struct {
    logic r;
    logic b;
    int   c;
    int   m;
    logic t;
    logic p;
  } vec_t;

  function automatic vec_t mk(logic r, logic b, int c, int m, logic t, logic p);
    vec_t v;
    v.r = r; v.b = b; v.c = c; v.m = m; v.t = t; v.p = p;
    return v;
  endfunction

  vec_t vecs[$];

  int pulses;
  int frozen;

  initial begin
    // Idle after reset, then a press held from the first edge after reset.
    vecs.push_back(mk(1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 2, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 1));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].b, vecs[i].r);
      check($sformatf("vec%0d_count", i), int'(count), vecs[i].c);
      check($sformatf("vec%0d_mode", i), int'(mode), vecs[i].m);
      check($sformatf("vec%0d_tick", i), int'(tick), int'(vecs[i].t));
      check($sformatf("vec%0d_pulse", i), int'(btn_pulse), int'(vecs[i].p));
    end

    // Two-cycle glitch must not qualify; a later full press still needs 2+DEBOUNCE edges.
    step(0, 1);
    step(1, 0);
    step(1, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0);
      check("glitch_pulse", int'(btn_pulse), 0);
    end
    check("glitch_mode", int'(mode), 0);
    for (int i = 1; i <= 6; i++) begin
      step(1, 0);
      check($sformatf("requal_pulse_e%0d", i), int'(btn_pulse), int'(i == 5));
    end
    check("requal_mode", int'(mode), 1);

    // Three separate presses walk UP -> DOWN -> PAUSE -> UP; PAUSE freezes count.
    step(0, 1);
    for (int n = 1; n <= 3; n++) begin
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
        step(1, 0);
        pulses += int'(btn_pulse);
      end
      for (int i = 0; i < 6; i++) begin
        step(0, 0);
        pulses += int'(btn_pulse);
      end
      check($sformatf("press%0d_pulses", n), pulses, 1);
      check($sformatf("press%0d_mode", n), int'(mode), n % 3);
      if (n == 2) begin
        frozen = int'(count);
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
          step(0, 0);
          pulses += int'(tick);
        end
        check("pause_ticks_seen", int'(pulses >= 3), 1);
        check("pause_count_frozen", int'(count), frozen);
      end
    end

    // Press qualifying on the same edge as a tick: step uses the old mode.
    step(0, 1);
    for (int i = 1; i <= 7; i++) step(0, 0);
    for (int i = 8; i <= 11; i++) step(1, 0);
    check("coincide_pre_count", int'(count), 2);
    check("coincide_pre_mode", int'(mode), 0);
    step(1, 0);
    check("coincide_count", int'(count), 3);
    check("coincide_mode", int'(mode), 1);
    check("coincide_tick", int'(tick), 1);
    check("coincide_pulse", int'(btn_pulse), 1);
    for (int i = 13; i <= 16; i++) step(1, 0);
    check("coincide_next_count", int'(count), 2);
    check("coincide_next_tick", int'(tick), 1);

    // Reset in the middle of debounce discards the press in progress.
    step(0, 1);
    for (int i = 1; i <= 5; i++) step(1, 0);
    for (int i = 6; i <= 16; i++) step(0, 0);
    for (int i = 17; i <= 19; i++) step(1, 0);
    check("midrst_pre_count", int'(count), 4);
    check("midrst_pre_mode", int'(mode), 1);
    step(1, 1);
    check("midrst_count", int'(count), 0);
    check("midrst_mode", int'(mode), 0);
    check("midrst_tick", int'(tick), 0);
    check("midrst_pulse", int'(btn_pulse), 0);
    for (int i = 1; i <= 5; i++) begin
      step(1, 0);
      check($sformatf("midrst_requal_e%0d", i), int'(btn_pulse), int'(i == 5));
      check($sformatf("midrst_tick_e%0d", i), int'(tick), int'(i == 4));
    end
    check("midrst_requal_mode", int'(mode), 1);

    // Randomized button runs with occasional reset, checked against the model.
    step(0, 1);
    for (int i = 0; i < 600; i++) begin
      automatic logic lvl = 1'($urandom_range(0, 1));
      automatic int   len = int'($urandom_range(1, 9));
      for (int j = 0; j < len; j++) begin
        step(lvl, ($urandom_range(0, 249) == 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
